pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port imem_req  input  1  fetch stage needs an instruction this cycle (level).
REQ-004 SHALL have port imem_resp  input  1  instruction memory done (single-cycle pulse).
REQ-005 SHALL have port dmem_req  input  1  MEM stage needs a data read/write this cycle (level).
REQ-006 SHALL have port dmem_resp  input  1  data memory done (single-cycle pulse).
REQ-007 SHALL have port load_use_hazard  input  1  ID instruction sources the rd of a load in EX.
REQ-008 SHALL have port br_taken  input  1  EX resolved a taken branch/jump; PC mux selects target.
REQ-009 SHALL have port load_pc  output  1  PC register load enable.
REQ-010 SHALL have ports load_if_id, load_id_ex, load_ex_mem, load_mem_wb  output  1 each  stage register load enables.
REQ-011 SHALL have ports flush_if_id, flush_id_ex  output  1 each  stage register loads an all-zero bubble instead of its input (qualified by its load).
REQ-012 SHALL have port stall_count  output  32  free-running count of stalled cycles.

Function
REQ-013 SHALL implement a two-state FSM: RUN, WAIT; plus registers i_done, d_done, pend_redirect, stall_count.
REQ-014 SHALL define i_miss = imem_req & ~imem_resp, d_miss = dmem_req & ~dmem_resp (RUN only).
REQ-015 In RUN with i_miss|d_miss: SHALL hold all loads/flushes 0, go to WAIT, set i_done <= ~i_miss, d_done <= ~d_miss.
REQ-016 In WAIT: SHALL set i_ok = i_done|imem_resp|~imem_req, d_ok = d_done|dmem_resp|~dmem_req; both ok -> advance cycle, go RUN, clear i_done/d_done; else hold all loads 0, i_done <= i_ok, d_done <= d_ok.
REQ-017 In RUN with no miss: SHALL perform an advance cycle.
REQ-018 Advance cycle, redirect = br_taken|pend_redirect: SHALL assert all five loads plus flush_if_id and flush_id_ex; clear pend_redirect.
REQ-019 Advance cycle, no redirect, load_use_hazard: SHALL assert load_id_ex, load_ex_mem, load_mem_wb, flush_id_ex; deassert load_pc, load_if_id, flush_if_id.
REQ-020 Advance cycle, neither: SHALL assert all five loads, no flushes.
REQ-021 Redirect SHALL take priority over load_use_hazard (hazarding instruction is squashed).
REQ-022 Any non-advance cycle with br_taken=1: SHALL set pend_redirect <= 1.
REQ-023 Responses arriving in different WAIT cycles SHALL each be remembered; advance occurs the cycle the last outstanding response arrives (zero added latency).
REQ-024 A miss/response pair in the same RUN cycle SHALL not stall (zero-latency hit).
REQ-025 stall_count SHALL increment by 1 every non-advance cycle with rst low, wrapping 0xFFFFFFFF -> 0.
REQ-026 Outputs SHALL be combinational from state and inputs; no output registered.

Reset
REQ-027 While rst=1 SHALL force all loads and flushes to 0, state RUN, i_done=d_done=pend_redirect=0, stall_count=0, immediately (asynchronously).
REQ-028 rst asserted mid-WAIT SHALL discard done flags and pending redirect; first cycle after release evaluated as RUN.

Verification
REQ-029 Hits: imem_req=imem_resp=1, dmem_req=0 for 10 cycles -> all loads 1 every cycle, stall_count=0.
REQ-030 I-miss: imem_req=1, imem_resp pulses 3 cycles later -> 3 cycles loads 0, advance on resp cycle, stall_count=3.
REQ-031 Split miss: both reqs miss, dmem_resp at cycle 2, imem_resp at cycle 5 -> advance only at cycle 5, stall_count=5.
REQ-032 Load-use: load_use_hazard=1, no miss -> load_pc=load_if_id=0, flush_id_ex=1, others load 1; same with br_taken=1 -> all loads 1, both flushes 1.
REQ-033 br_taken pulse during WAIT then deasserted -> advance cycle shows flush_if_id=flush_id_ex=1, pend_redirect cleared next cycle.
REQ-034 Counter preset near 0xFFFFFFFE (force or long run) plus 3 stall cycles -> wraps to 0x00000001; rst asserted mid-WAIT -> outputs 0 asynchronously, stall_count=0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: holds every stage while an instruction or data
// memory access is outstanding and inserts bubbles for load-use hazards and redirects.
module pipeline_ctrl (
    input  logic                clk,
    input  logic                rst,
    input  logic                imem_req,
    input  logic                imem_resp,
    input  logic                dmem_req,
    input  logic                dmem_resp,
    input  logic                load_use_hazard,
    input  logic                br_taken,
    output logic                load_pc,
    output logic                load_if_id,
    output logic                load_id_ex,
    output logic                load_ex_mem,
    output logic                load_mem_wb,
    output logic                flush_if_id,
    output logic                flush_id_ex,
    output logic [31:0]         stall_count
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               i_done_q, i_done_d;
    logic               d_done_q, d_done_d;
    logic               pend_redirect_q, pend_redirect_d;
    logic [CNT_W-1:0]   stall_count_q, stall_count_d;

    logic i_miss, d_miss, i_ok, d_ok, advance, redirect;

    // Miss / completion decode shared by next-state and output logic
    always_comb begin
        i_miss   = imem_req & ~imem_resp;
        d_miss   = dmem_req & ~dmem_resp;
        i_ok     = i_done_q | imem_resp | ~imem_req;
        d_ok     = d_done_q | dmem_resp | ~dmem_req;
        advance  = (state_q == RUN) ? ~(i_miss | d_miss) : (i_ok & d_ok);
        redirect = br_taken | pend_redirect_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= RUN;
            i_done_q        <= 1'b0;
            d_done_q        <= 1'b0;
            pend_redirect_q <= 1'b0;
            stall_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            i_done_q        <= i_done_d;
            d_done_q        <= d_done_d;
            pend_redirect_q <= pend_redirect_d;
            stall_count_q   <= stall_count_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        i_done_d        = i_done_q;
        d_done_d        = d_done_q;
        pend_redirect_d = pend_redirect_q;
        stall_count_d   = stall_count_q;
        case (state_q)
            RUN: begin
                if (i_miss | d_miss) begin
                    state_d  = WAIT;
                    i_done_d = ~i_miss;
                    d_done_d = ~d_miss;
                end
            end
            WAIT: begin
                // Done flags latch responses that arrive in different stall cycles
                if (i_ok & d_ok) begin
                    state_d  = RUN;
                    i_done_d = 1'b0;
                    d_done_d = 1'b0;
                end else begin
                    i_done_d = i_ok;
                    d_done_d = d_ok;
                end
            end
            default: state_d = RUN;
        endcase
        if (advance) begin
            pend_redirect_d = 1'b0;
        end else begin
            stall_count_d = stall_count_q + CNT_W'(1);
            if (br_taken) begin
                pend_redirect_d = 1'b1;
            end
        end
    end

    // Redirect outranks load-use: the hazarding instruction is squashed anyway
    always_comb begin
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        load_id_ex  = 1'b0;
        load_ex_mem = 1'b0;
        load_mem_wb = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (!rst && advance) begin
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            if (redirect) begin
                load_pc     = 1'b1;
                load_if_id  = 1'b1;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (load_use_hazard) begin
                flush_id_ex = 1'b1;
            end else begin
                load_pc    = 1'b1;
                load_if_id = 1'b1;
            end
        end
    end

    assign stall_count = stall_count_q;

endmodule
